mac_cluster_drain: RTL and testbench

Result-collection stage that sits directly downstream of the MAC quad-cluster. It watches the cluster's `en`, counts enabled accumulate cycles up to a programmed length, and snapshots the four cluster outputs once the pipeline has settled. It then streams only the words that are meaningful for the active mode (single, dual or quad) over a valid/ready interface to the fabric or readout logic.

---
 rtl/mac_cluster_drain.sv | 163 ++++++++++++++++
 tb/tb_mac_cluster_drain.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mac_cluster_drain.sv
// Result collector behind the MAC quad-cluster: counts enabled accumulate cycles,
// snapshots the cluster outputs after the pipeline settles, then streams the mode-relevant words.
`ifndef MAC_ACC_WIDTH
`define MAC_ACC_WIDTH 32
`endif

module mac_cluster_drain #(
    parameter int ACC_W = `MAC_ACC_WIDTH,
    parameter int CNT_W = 16,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] len,
    input  logic             en_in,
    input  logic [ACC_W-1:0] in0,
    input  logic [ACC_W-1:0] in1,
    input  logic [ACC_W-1:0] in2,
    input  logic [ACC_W-1:0] in3,
    output logic [ACC_W-1:0] out_data,
    output logic [1:0]       out_idx,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow
);
    typedef enum logic [1:0] {IDLE, COUNT, SETTLE, DRAIN} state_t;

    state_t           r_state;
    logic [1:0]       r_mode;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_dly;
    logic [ACC_W-1:0] r_out_data;
    logic [1:0]       r_out_idx;
    logic             r_out_last;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_overflow;

    logic [ACC_W-1:0] w_in   [4];
    logic [ACC_W-1:0] w_snap [4];
    logic             w_capture;
    logic             w_handshake;
    logic [1:0]       w_first_idx;
    logic [1:0]       w_next_idx;

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    assign w_capture   = (r_state == SETTLE) && (r_dly == 4'd0);
    assign w_handshake = r_out_valid && out_ready;

    // Dual mode emits only the combined-pair results (1, 3); quad only the full sum (3).
    always_comb begin
        w_first_idx = 2'd0;
        case (r_mode)
            2'b01:   w_first_idx = 2'd1;
            2'b10:   w_first_idx = 2'd3;
            default: w_first_idx = 2'd0;
        endcase
    end

    assign w_next_idx = r_out_idx + ((r_mode == 2'b01) ? 2'd2 : 2'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_snap
            logic [ACC_W-1:0] r_snap;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_snap <= '0;
                end else if (w_capture) begin
                    r_snap <= w_in[gi];
                end
            end
            assign w_snap[gi] = r_snap;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_mode      <= 2'b00;
            r_len       <= '0;
            r_cnt       <= '0;
            r_dly       <= 4'd0;
            r_out_data  <= '0;
            r_out_idx   <= 2'd0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode     <= (mode == 2'b11) ? 2'b00 : mode;
                        r_len      <= (len == '0) ? CNT_W'(1) : len;
                        r_cnt      <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= COUNT;
                    end
                end
                COUNT: begin
                    if (en_in) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == r_len - CNT_W'(1)) begin
                            r_dly   <= 4'(LAT - 1);
                            r_state <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (en_in) begin
                        r_overflow <= 1'b1;
                    end
                    if (r_dly == 4'd0) begin
                        // First word is the same value the snapshot captures on this edge.
                        r_out_valid <= 1'b1;
                        r_out_idx   <= w_first_idx;
                        r_out_data  <= w_in[w_first_idx];
                        r_out_last  <= (r_mode == 2'b10);
                        r_state     <= DRAIN;
                    end else begin
                        r_dly <= r_dly - 4'd1;
                    end
                end
                DRAIN: begin
                    if (en_in) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_handshake) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_out_idx  <= w_next_idx;
                            r_out_data <= w_snap[w_next_idx];
                            r_out_last <= (w_next_idx == 2'd3);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_mac_cluster_drain.sv
// Bench for mac_cluster_drain: randomized runs checked against a run-level model
// (enable counting, capture at T+LAT, per-mode word list, sticky overflow).
module tb_mac_cluster_drain;
    localparam int ACC_W = 32;
    localparam int CNT_W = 16;
    localparam int LAT   = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] len = '0;
    logic             en_in = 1'b0;
    logic [ACC_W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [ACC_W-1:0] out_data;
    logic [1:0]       out_idx;
    logic             out_last, out_valid, out_ready = 1'b0, busy, overflow;

    int   tests = 0;
    int   fails = 0;
    logic exp_ovf = 1'b0;

    always #5 clk = ~clk;

    mac_cluster_drain #(.ACC_W(ACC_W), .CNT_W(CNT_W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len), .en_in(en_in),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ins();
        in0 = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
    endtask

    // One collection run: start is driven in the current cycle (must be IDLE).
    task automatic do_run(input logic [1:0] m, input int l, input int en_pct, input int rdy_pct,
                          input bit ovf_pulse, input bit busy_start, input int abort_at);
        int               eff, seen, guard, popped;
        int               q[$];
        logic [ACC_W-1:0] snap [4];
        logic [1:0]       mm;
        eff = (l == 0) ? 1 : l;
        mm  = (m == 2'b11) ? 2'b00 : m;
        case (mm)
            2'b01:   q = {1, 3};
            2'b10:   q = {3};
            default: q = {0, 1, 2, 3};
        endcase
        start = 1'b1; mode = m; len = CNT_W'(l); en_in = 1'b0; out_ready = 1'(rdy_pct > 0);
        @(negedge clk);
        chk("idle_valid", 64'(out_valid), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_ovf", 64'(overflow), 64'(exp_ovf));
        step();
        start = 1'b0; mode = 2'($urandom); len = CNT_W'($urandom);
        exp_ovf = 1'b0;
        seen = 0; guard = 0;
        while (seen < eff) begin
            en_in = (guard > 40) || ($urandom_range(99) < en_pct);
            rand_ins();
            @(negedge clk);
            chk("count_busy", 64'(busy), 64'(1));
            chk("count_valid", 64'(out_valid), 64'(0));
            chk("count_ovf", 64'(overflow), 64'(0));
            if (en_in) seen++;
            guard++;
            step();
        end
        for (int j = 1; j <= LAT; j++) begin
            en_in = 1'b0;
            rand_ins();
            if (j == LAT) begin
                snap[0] = in0; snap[1] = in1; snap[2] = in2; snap[3] = in3;
            end
            @(negedge clk);
            chk("settle_valid", 64'(out_valid), 64'(0));
            chk("settle_busy", 64'(busy), 64'(1));
            step();
        end
        popped = 0; guard = 0;
        while (q.size() > 0) begin
            en_in = ovf_pulse && (guard == 1);
            start = busy_start && (guard == 0);
            mode  = 2'($urandom);
            rand_ins();
            out_ready = (guard > 60) || ($urandom_range(99) < rdy_pct);
            if (abort_at == popped) begin
                out_ready = 1'b0;
                rst = 1'b0;
            end
            @(negedge clk);
            chk("drain_valid", 64'(out_valid), 64'(1));
            chk("drain_idx", 64'(out_idx), 64'(q[0]));
            chk("drain_data", 64'(out_data), 64'(snap[q[0]]));
            chk("drain_last", 64'(out_last), 64'(q.size() == 1));
            chk("drain_ovf", 64'(overflow), 64'(exp_ovf));
            if (en_in) exp_ovf = 1'b1;
            if (abort_at == popped) begin
                step();
                rst = 1'b1; en_in = 1'b0; start = 1'b0;
                @(negedge clk);
                chk("rst_valid", 64'(out_valid), 64'(0));
                chk("rst_last", 64'(out_last), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_ovf", 64'(overflow), 64'(0));
                chk("rst_data", 64'(out_data), 64'(0));
                chk("rst_idx", 64'(out_idx), 64'(0));
                exp_ovf = 1'b0;
                step();
                return;
            end
            if (out_ready) begin
                void'(q.pop_front());
                popped++;
            end
            guard++;
            step();
            start = 1'b0;
        end
        en_in = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_last", 64'(out_last), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_ovf", 64'(overflow), 64'(0));
        chk("reset_data", 64'(out_data), 64'(0));
        chk("reset_idx", 64'(out_idx), 64'(0));
        step();
        rst = 1'b1;
        step();

        do_run(2'b00, 3, 100, 100, 1'b0, 1'b0, -1);   // single, back-to-back drain
        do_run(2'b10, 1, 100, 100, 1'b0, 1'b0, -1);   // quad, one word
        do_run(2'b01, 5, 70, 25, 1'b0, 1'b0, -1);     // dual with backpressure
        do_run(2'b00, 4, 50, 100, 1'b0, 1'b0, -1);    // gapped enables
        do_run(2'b01, 0, 50, 100, 1'b0, 1'b0, -1);    // len 0 acts as 1
        do_run(2'b00, 2, 100, 20, 1'b1, 1'b1, -1);    // overflow + start while busy

        // en_in in IDLE must not disturb the sticky flag
        en_in = 1'b1;
        step();
        en_in = 1'b0;
        @(negedge clk);
        chk("idle_en_ovf", 64'(overflow), 64'(exp_ovf));
        chk("idle_en_busy", 64'(busy), 64'(0));
        step();

        do_run(2'b00, 2, 100, 100, 1'b0, 1'b0, 1);    // reset while idx-1 word pending
        do_run(2'b00, 3, 80, 100, 1'b0, 1'b0, -1);    // clean run after abort
        do_run(2'b11, 2, 100, 60, 1'b0, 1'b0, -1);    // reserved mode behaves as single

        for (int r = 0; r < 20; r++) begin
            do_run(2'($urandom), int'($urandom_range(6)), int'($urandom_range(30, 100)),
                   int'($urandom_range(20, 100)), 1'($urandom), 1'($urandom), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
